// File: rtl/gate_reduce_unit.sv
// gate_reduce_unit
//   Streams a frame of 1..MAX_LEN WIDTH-bit operands over a valid/ready input
//   and folds them bitwise with one selectable logic op. Emits one result per
//   frame on a valid/ready output.
//
//   Ports
//     clk, rst                 rising-edge clock, async active-high reset
//     start, op, len           frame request (sampled only in IDLE)
//     busy                     high in ACCUM and DONE
//     err                      one-cycle pulse on a rejected start
//     in_valid/in_ready/in_data    operand stream
//     out_valid/out_ready/out_data reduced result
//
//   op: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR,
//       110 PASS (last operand), 111 illegal

// Per-bit fold step. The inverting ops fold with their base op; the final
// inversion is applied once, at the result register.
module gate_reduce_lane (
  input  logic       first,
  input  logic [2:0] op,
  input  logic       acc,
  input  logic       data,
  output logic       nxt
);
  always_comb begin
    nxt = data;
    if (!first) begin
      unique case (op)
        3'd0, 3'd3: nxt = acc & data;
        3'd1, 3'd4: nxt = acc | data;
        3'd2, 3'd5: nxt = acc ^ data;
        default:    nxt = data;       // PASS keeps the latest operand
      endcase
    end
  end
endmodule

module gate_reduce_unit #(
  parameter int WIDTH   = 8,
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             err,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [LEN_W-1:0] count;
  logic [LEN_W-1:0] len_q;
  logic [2:0]       op_q;

  logic beat;
  logic last_beat;
  logic start_bad;
  logic invert;

  // Handshake outputs decode from the state register only, so no input can
  // reach an output combinationally.
  assign busy      = (state == ACCUM) || (state == DONE);
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);

  assign beat      = in_valid && in_ready;
  assign last_beat = beat && (count == len_q - LEN_W'(1));
  assign start_bad = (len == '0) || (len > LEN_W'(MAX_LEN)) || (op == 3'b111);
  assign invert    = (op_q == 3'd3) || (op_q == 3'd4) || (op_q == 3'd5);

  for (genvar b = 0; b < WIDTH; b++) begin : g_lane
    gate_reduce_lane u_lane (
      .first (count == '0),
      .op    (op_q),
      .acc   (acc[b]),
      .data  (in_data[b]),
      .nxt   (acc_nxt[b])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      err      <= 1'b0;
      acc      <= '0;
      count    <= '0;
      op_q     <= '0;
      len_q    <= '0;
      out_data <= '0;
    end else begin
      err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (start_bad) begin
              err <= 1'b1;
            end else begin
              op_q  <= op;
              len_q <= len;
              count <= '0;
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (beat) begin
            acc   <= acc_nxt;
            count <= count + LEN_W'(1);
            if (last_beat) begin
              // Result is captured from the fold of the final operand so it
              // is valid on the very first DONE cycle.
              out_data <= invert ? ~acc_nxt : acc_nxt;
              state    <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_reduce_unit.sv
module tb_gate_reduce_unit;

  localparam int WIDTH = 8;
  localparam int MAX_LEN = 16;
  localparam int LEN_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [2:0]       op;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             err;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  int checks = 0;
  int errors = 0;

  gate_reduce_unit #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .len(len),
    .busy(busy), .err(err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required earlier", $time);
    $fatal(1);
  end

  // Inputs change on the falling edge; outputs are checked on the falling edge.
  task automatic kick(input logic [2:0] o, input logic [LEN_W-1:0] l);
    @(negedge clk);
    start = 1'b1; op = o; len = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Presents one operand for one cycle; the caller's next negedge sees its effect.
  task automatic beat(input logic [WIDTH-1:0] d);
    in_valid = 1'b1; in_data = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 0; op = 0; len = 0; in_valid = 0; in_data = 0; out_ready = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, err, in_ready, out_valid} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0000", {busy, err, in_ready, out_valid});
    end
    checks++;
    if (out_data !== 8'h00) begin
      errors++; $display("FAIL reset_data: got %h expected 00", out_data);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_and3;
    kick(3'b000, 5'd3);
    checks++;
    if ({busy, in_ready, out_valid} !== 3'b110) begin
      errors++; $display("FAIL and3_accum: got %b expected 110", {busy, in_ready, out_valid});
    end
    beat(8'hF0); beat(8'h3C); beat(8'hFF);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h30 || in_ready !== 1'b0) begin
      errors++; $display("FAIL and3_result: got v=%b d=%h r=%b expected v=1 d=30 r=0", out_valid, out_data, in_ready);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h30) begin
      errors++; $display("FAIL and3_idle: got b=%b v=%b d=%h expected b=0 v=0 d=30", busy, out_valid, out_data);
    end
  endtask

  task automatic test_invert_ops;
    kick(3'b101, 5'd2);
    beat(8'hAA); beat(8'h0F);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h5A) begin
      errors++; $display("FAIL xnor2: got v=%b d=%h expected v=1 d=5a", out_valid, out_data);
    end
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    kick(3'b011, 5'd1);
    beat(8'h0F);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hF0) begin
      errors++; $display("FAIL nand1: got v=%b d=%h expected v=1 d=f0", out_valid, out_data);
    end
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic test_err;
    logic [2:0]       ops [3] = '{3'b000, 3'b000, 3'b111};
    logic [LEN_W-1:0] lens[3] = '{5'd0, 5'd17, 5'd2};
    for (int i = 0; i < 3; i++) begin
      kick(ops[i], lens[i]);
      checks++;
      if (err !== 1'b1 || {busy, in_ready, out_valid} !== 3'b000) begin
        errors++; $display("FAIL err_pulse%0d: got err=%b ctrl=%b expected err=1 ctrl=000", i, err, {busy, in_ready, out_valid});
      end
      @(negedge clk);
      checks++;
      if (err !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL err_clear%0d: got err=%b busy=%b expected 0 0", i, err, busy);
      end
    end
    // MAX_LEN itself is legal
    kick(3'b001, 5'd16);
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL len_max_ok: got err=%b busy=%b expected 0 1", err, busy);
    end
    for (int i = 0; i < 16; i++) beat(8'(1 << (i % 8)));
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hFF) begin
      errors++; $display("FAIL or16: got v=%b d=%h expected v=1 d=ff", out_valid, out_data);
    end
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic test_gaps;
    logic             vpat[6] = '{1, 0, 1, 0, 1, 1};
    logic [WIDTH-1:0] dq[4]   = '{8'h01, 8'h02, 8'h04, 8'h08};
    int k = 0;
    kick(3'b010, 5'd4);
    for (int i = 0; i < 6; i++) begin
      in_valid = vpat[i];
      in_data  = vpat[i] ? dq[k] : 8'hFF;   // junk on idle cycles must be ignored
      if (vpat[i]) k++;
      @(negedge clk);
      if (i < 5) begin
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
          errors++; $display("FAIL gaps_mid%0d: got v=%b r=%b expected v=0 r=1", i, out_valid, in_ready);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h0F) begin
      errors++; $display("FAIL xor_gaps: got v=%b d=%h expected v=1 d=0f", out_valid, out_data);
    end
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    kick(3'b001, 5'd2);
    beat(8'h01); beat(8'h80);
    for (int i = 0; i < 5; i++) begin
      start = i[0]; op = 3'b000; len = 5'd0;   // illegal starts too: no err while busy
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h81 || in_ready !== 1'b0 || err !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL bp_hold%0d: got v=%b d=%h r=%b e=%b b=%b expected v=1 d=81 r=0 e=0 b=1",
                           i, out_valid, out_data, in_ready, err, busy);
      end
    end
    // legal start coincident with the handshake must be dropped
    start = 1'b1; op = 3'b000; len = 5'd2; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL bp_release: got v=%b b=%b e=%b expected 0 0 0", out_valid, busy, err);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL bp_start_dropped: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_reset_midframe;
    kick(3'b000, 5'd4);
    beat(8'hFF); beat(8'h0F);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, err, in_ready, out_valid} !== 4'b0000 || out_data !== 8'h00) begin
      errors++; $display("FAIL rst_async: got ctrl=%b d=%h expected 0000 00", {busy, err, in_ready, out_valid}, out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    kick(3'b110, 5'd2);
    beat(8'h11); beat(8'h22);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h22) begin
      errors++; $display("FAIL pass2: got v=%b d=%h expected v=1 d=22", out_valid, out_data);
    end
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL pass2_idle: got busy=%b expected 0", busy);
    end
  endtask

  initial begin
    test_reset;
    test_and3;
    test_invert_ops;
    test_err;
    test_gaps;
    test_backpressure;
    test_reset_midframe;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
